vga_pattern_sequencer: RTL

Controller that selects which VGA test pattern the pattern generator draws and when it changes. It watches the column/row counts from the VGA counter, detects frame start and vertical-blanking entry, and accepts manual next/previous requests or auto-advances every N frames. All pattern changes take effect only at vertical-blanking entry, so a visible frame never tears. It sits between the VGA counter and the pattern-generation logic that feeds the sync/porch stage.

---
 rtl/vga_pattern_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/vga_pattern_sequencer.sv
// Test-pattern selector for the VGA pipeline: detects frame-start and vblank-entry from the
// counter stream, queues manual next/prev requests, and applies steps only at vblank entry.
module vga_pattern_sequencer #(
   parameter int unsigned c_PATTERN_BITS       = 3,
   parameter int unsigned c_NUM_PATTERNS       = 6,
   parameter int unsigned c_FRAMES_PER_PATTERN = 120,
   parameter int unsigned c_ACTIVE_COLS        = 640,
   parameter int unsigned c_ACTIVE_ROWS        = 480
) (
   input  logic                      i_Clk,
   input  logic                      i_Rst_L,
   input  logic [9:0]                i_Col_Count,
   input  logic [9:0]                i_Row_Count,
   input  logic                      i_Next,
   input  logic                      i_Prev,
   input  logic                      i_Auto_En,
   output logic [c_PATTERN_BITS-1:0] o_Pattern,
   output logic                      o_Frame_Start,
   output logic                      o_VBlank_Start,
   output logic                      o_Pending,
   output logic                      o_Switch_Ack,
   output logic [7:0]                o_Frame_Count
);

   localparam int unsigned COORD_W = 10;
   localparam int unsigned CNT_W   = 8;

   localparam logic [c_PATTERN_BITS-1:0] LAST_PAT   = c_PATTERN_BITS'(c_NUM_PATTERNS - 1);
   localparam logic [CNT_W-1:0]          LAST_FRAME = CNT_W'(c_FRAMES_PER_PATTERN - 1);
   localparam logic [COORD_W-1:0]        VBLANK_ROW = COORD_W'(c_ACTIVE_ROWS);

   // Elaboration-time guards on the configuration.
   if (c_NUM_PATTERNS < 2 || c_NUM_PATTERNS > (1 << c_PATTERN_BITS)) begin : g_bad_num_patterns
      $error("c_NUM_PATTERNS out of range for c_PATTERN_BITS");
   end
   if (c_FRAMES_PER_PATTERN < 1 || c_FRAMES_PER_PATTERN > 256) begin : g_bad_frames
      $error("c_FRAMES_PER_PATTERN must be 1..256");
   end
   if (c_ACTIVE_COLS < 1 || c_ACTIVE_COLS > 1023 || c_ACTIVE_ROWS < 1 || c_ACTIVE_ROWS > 1023)
   begin : g_bad_geometry
      $error("active geometry does not fit the 10-bit counters");
   end

   typedef enum logic [1:0] {
      PEND_NONE = 2'd0,
      PEND_NEXT = 2'd1,
      PEND_PREV = 2'd2
   } pend_t;

   pend_t                      pend_q;
   pend_t                      pend_next_c;
   logic [COORD_W-1:0]         prev_col_q;
   logic [COORD_W-1:0]         prev_row_q;
   logic [c_PATTERN_BITS-1:0]  pattern_next_c;
   logic [c_PATTERN_BITS-1:0]  pattern_inc_c;
   logic [c_PATTERN_BITS-1:0]  pattern_dec_c;
   logic [CNT_W-1:0]           count_next_c;
   logic                       ack_next_c;
   logic                       frame_start_c;
   logic                       vblank_c;

   // Edge-qualified events: a held counter value never produces a second pulse.
   always_comb begin
      frame_start_c = (i_Col_Count == '0) && (i_Row_Count == '0) &&
                      !((prev_col_q == '0) && (prev_row_q == '0));
      vblank_c      = (i_Col_Count == '0) && (i_Row_Count == VBLANK_ROW) &&
                      !((prev_col_q == '0) && (prev_row_q == VBLANK_ROW));
   end

   always_comb begin
      pattern_inc_c = (o_Pattern == LAST_PAT) ? '0 : o_Pattern + c_PATTERN_BITS'(1);
      pattern_dec_c = (o_Pattern == '0) ? LAST_PAT : o_Pattern - c_PATTERN_BITS'(1);
   end

   // Next-state: the request sampled at the vblank edge is queued, not applied.
   always_comb begin
      pend_next_c    = pend_q;
      pattern_next_c = o_Pattern;
      count_next_c   = o_Frame_Count;
      ack_next_c     = 1'b0;

      if (vblank_c) begin
         pend_next_c = PEND_NONE;
         case (pend_q)
            PEND_NEXT: begin
               pattern_next_c = pattern_inc_c;
               count_next_c   = '0;
               ack_next_c     = 1'b1;
            end
            PEND_PREV: begin
               pattern_next_c = pattern_dec_c;
               count_next_c   = '0;
               ack_next_c     = 1'b1;
            end
            default: begin
               if (i_Auto_En) begin
                  if (o_Frame_Count == LAST_FRAME) begin
                     pattern_next_c = pattern_inc_c;
                     count_next_c   = '0;
                     ack_next_c     = 1'b1;
                  end else begin
                     count_next_c = o_Frame_Count + CNT_W'(1);
                  end
               end else begin
                  count_next_c = '0;
               end
            end
         endcase
      end

      if (i_Next && !i_Prev) begin
         pend_next_c = PEND_NEXT;
      end else if (i_Prev && !i_Next) begin
         pend_next_c = PEND_PREV;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         pend_q         <= PEND_NONE;
         prev_col_q     <= '0;
         prev_row_q     <= '0;
         o_Pattern      <= '0;
         o_Frame_Start  <= 1'b0;
         o_VBlank_Start <= 1'b0;
         o_Pending      <= 1'b0;
         o_Switch_Ack   <= 1'b0;
         o_Frame_Count  <= '0;
      end else begin
         pend_q         <= pend_next_c;
         prev_col_q     <= i_Col_Count;
         prev_row_q     <= i_Row_Count;
         o_Pattern      <= pattern_next_c;
         o_Frame_Start  <= frame_start_c;
         o_VBlank_Start <= vblank_c;
         o_Pending      <= (pend_next_c != PEND_NONE);
         o_Switch_Ack   <= ack_next_c;
         o_Frame_Count  <= count_next_c;
      end
   end

endmodule
